// File: rtl/ddr_mport_pkg.sv
// Shared constants and types for the DDR app-interface multi-port arbiter.
package ddr_mport_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    CALIB = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2
  } mport_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ddr_mport_tag_fifo.sv
// In-order FIFO of issuing-channel tags for outstanding reads; push and pop may coincide.
module ddr_mport_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  // Extra pointer MSB tells a full ring from an empty one.
  assign pop_data = mem[rd_ptr[PW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/ddr_app_mport_arb.sv
// Round-robin NUM_CH-port front end onto the DDR app interface with tagged read return.
// Optional DDR_MPORT_PERF_CNT_EN adds per-channel saturating read/write counters.
module ddr_app_mport_arb
  import ddr_mport_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int APP_ADDR_WIDTH = 32,
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH/8,
  parameter int RD_TAG_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               init_calib_complete,
  input  logic [NUM_CH-1:0]                  ch_req_valid,
  output logic [NUM_CH-1:0]                  ch_req_ready,
  input  logic [NUM_CH-1:0]                  ch_req_we,
  input  logic [NUM_CH*APP_ADDR_WIDTH-1:0]   ch_req_addr,
  input  logic [NUM_CH*APP_DATA_WIDTH-1:0]   ch_req_wdata,
  input  logic [NUM_CH*APP_MASK_WIDTH-1:0]   ch_req_wmask,
  output logic [NUM_CH-1:0]                  ch_rd_valid,
  output logic [APP_DATA_WIDTH-1:0]          ch_rd_data,
  output logic [APP_ADDR_WIDTH-1:0]          app_addr,
  output logic [2:0]                         app_cmd,
  output logic                               app_en,
  input  logic                               app_rdy,
  output logic [APP_DATA_WIDTH-1:0]          app_wdf_data,
  output logic [APP_MASK_WIDTH-1:0]          app_wdf_mask,
  output logic                               app_wdf_wren,
  output logic                               app_wdf_end,
  input  logic                               app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]          app_rd_data,
  input  logic                               app_rd_data_valid,
  output logic                               err_orphan_rd
`ifdef DDR_MPORT_PERF_CNT_EN
  ,
  output logic [NUM_CH*32-1:0]               perf_rd_cnt,
  output logic [NUM_CH*32-1:0]               perf_wr_cnt
`endif
);

  localparam int CW = ch_idx_w(NUM_CH);
  typedef logic [CW-1:0] ch_idx_t;

  typedef struct packed {
    logic                      we;
    logic [APP_ADDR_WIDTH-1:0] addr;
    logic [APP_DATA_WIDTH-1:0] wdata;
    logic [APP_MASK_WIDTH-1:0] wmask;
    ch_idx_t                   ch;
  } hold_t;

  mport_state_t state, state_nxt;
  ch_idx_t      rr_ptr, gnt_idx, tag_out;
  hold_t        hold;
  logic [NUM_CH-1:0] elig;
  logic gnt_any, cmd_done, wdf_done, cmd_fire, wdf_fire, issue_done;
  logic tag_full, tag_empty, tag_push, tag_pop;

  assign cmd_fire   = app_en & app_rdy;
  assign wdf_fire   = app_wdf_wren & app_wdf_rdy;
  assign issue_done = (state == ISSUE) && (cmd_done || cmd_fire) &&
                      (!hold.we || wdf_done || wdf_fire);
  assign elig       = ch_req_valid & (ch_req_we | {NUM_CH{~tag_full}});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CALIB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CALIB:   if (init_calib_complete) state_nxt = IDLE;
      IDLE:    if (!init_calib_complete) state_nxt = CALIB;
               else if (gnt_any)         state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = init_calib_complete ? IDLE : CALIB;
      default: state_nxt = CALIB;
    endcase
  end

  // First eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx          = 0;
    gnt_any      = 1'b0;
    gnt_idx      = '0;
    ch_req_ready = '0;
    if (state == IDLE && init_calib_complete) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!gnt_any && elig[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = ch_idx_t'(idx);
        end
      end
    end
    if (gnt_any) ch_req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      hold         <= '0;
      app_en       <= 1'b0;
      app_cmd      <= 3'b000;
      app_wdf_wren <= 1'b0;
      cmd_done     <= 1'b0;
      wdf_done     <= 1'b0;
    end else if (gnt_any) begin
      hold.we      <= ch_req_we[gnt_idx];
      hold.addr    <= ch_req_addr[int'(gnt_idx)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
      hold.wdata   <= ch_req_wdata[int'(gnt_idx)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
      hold.wmask   <= ch_req_wmask[int'(gnt_idx)*APP_MASK_WIDTH +: APP_MASK_WIDTH];
      hold.ch      <= gnt_idx;
      app_en       <= 1'b1;
      app_cmd      <= ch_req_we[gnt_idx] ? APP_CMD_WR : APP_CMD_RD;
      app_wdf_wren <= ch_req_we[gnt_idx];
      cmd_done     <= 1'b0;
      wdf_done     <= 1'b0;
      rr_ptr       <= (int'(gnt_idx) == NUM_CH-1) ? '0 : ch_idx_t'(gnt_idx + 1'b1);
    end else begin
      if (cmd_fire) begin
        app_en   <= 1'b0;
        cmd_done <= 1'b1;
      end
      if (wdf_fire) begin
        app_wdf_wren <= 1'b0;
        wdf_done     <= 1'b1;
      end
    end
  end

  assign app_addr     = hold.addr;
  assign app_wdf_data = hold.wdata;
  assign app_wdf_mask = hold.wmask;
  assign app_wdf_end  = app_wdf_wren;

  // Tag enters on read-command acceptance; beats with no tag are dropped and flagged.
  assign tag_push = cmd_fire & ~hold.we;
  assign tag_pop  = app_rd_data_valid & ~tag_empty;

  ddr_mport_tag_fifo #(.DEPTH(RD_TAG_DEPTH), .W(CW)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (hold.ch),
    .pop       (tag_pop),
    .pop_data  (tag_out),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_rd_valid   <= '0;
      ch_rd_data    <= '0;
      err_orphan_rd <= 1'b0;
    end else begin
      ch_rd_valid <= '0;
      if (tag_pop) begin
        ch_rd_valid[tag_out] <= 1'b1;
        ch_rd_data           <= app_rd_data;
      end
      if (app_rd_data_valid && tag_empty) err_orphan_rd <= 1'b1;
    end
  end

`ifdef DDR_MPORT_PERF_CNT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_perf
    logic [31:0] rd_cnt, wr_cnt;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (ch_rd_valid[i] && rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 1'b1;
        if (issue_done && hold.we && hold.ch == ch_idx_t'(i) && wr_cnt != 32'hFFFF_FFFF)
          wr_cnt <= wr_cnt + 1'b1;
      end
    end
    assign perf_rd_cnt[i*32 +: 32] = rd_cnt;
    assign perf_wr_cnt[i*32 +: 32] = wr_cnt;
  end
`endif

endmodule

// File: tb/tb_ddr_app_mport_arb.sv
// Directed scoreboard bench for ddr_app_mport_arb (4 channels, 16 read tags).
module tb_ddr_app_mport_arb;
  import ddr_mport_pkg::*;

  localparam int NCH = 4, AW = 32, DW = 64, MW = 8, TD = 16;

  logic clk = 1'b0, rst_n = 1'b0, init_calib_complete = 1'b0;
  logic [NCH-1:0]    ch_req_valid = '0, ch_req_we = '0;
  logic [NCH-1:0]    ch_req_ready, ch_rd_valid;
  logic [NCH*AW-1:0] ch_req_addr = '0;
  logic [NCH*DW-1:0] ch_req_wdata = '0;
  logic [NCH*MW-1:0] ch_req_wmask = '0;
  logic [DW-1:0]     ch_rd_data, app_wdf_data, app_rd_data;
  logic [AW-1:0]     app_addr;
  logic [2:0]        app_cmd;
  logic [MW-1:0]     app_wdf_mask;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid, err_orphan_rd;

  always #5 clk = ~clk;

  ddr_app_mport_arb #(.NUM_CH(NCH), .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
                      .APP_MASK_WIDTH(MW), .RD_TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_we(ch_req_we),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata), .ch_req_wmask(ch_req_wmask),
    .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .err_orphan_rd(err_orphan_rd)
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [MW-1:0] wmask; } req_t;
  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wdf_t;
  typedef struct { logic [NCH-1:0] oh; logic [DW-1:0] data; } rd_t;

  req_t req_q [NCH][$];
  cmd_t cmd_q [$];
  wdf_t wdf_q [$];
  rd_t  rd_q  [$];
  int n_chk = 0, n_pass = 0;
  logic [NCH-1:0] rdy_snap = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic req_t mk(input int ch, input logic we, input int seq);
    req_t r;
    r.we    = we;
    r.addr  = 32'((ch << 24) | (seq << 6));
    r.wdata = {32'(32'hC0DE_0000 + ch), 32'(seq * 7 + 1)};
    r.wmask = 8'(ch * 16 + seq);
    return r;
  endfunction

  task automatic exp_cmd(input req_t r);
    cmd_t c;
    wdf_t w;
    c.cmd  = r.we ? APP_CMD_WR : APP_CMD_RD;
    c.addr = r.addr;
    cmd_q.push_back(c);
    if (r.we) begin
      w.data = r.wdata;
      w.mask = r.wmask;
      wdf_q.push_back(w);
    end
  endtask

  task automatic exp_rd(input int ch, input logic [DW-1:0] d);
    rd_t x;
    x.oh   = NCH'(1 << ch);
    x.data = d;
    rd_q.push_back(x);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int c = 0; c < budget && (cmd_q.size() + wdf_q.size()) != 0; c++) @(negedge clk);
    chk(tag, 64'(cmd_q.size() + wdf_q.size()), 64'd0);
  endtask

  task automatic wait_rd(input string tag, input int budget);
    for (int c = 0; c < budget && rd_q.size() != 0; c++) @(negedge clk);
    chk(tag, 64'(rd_q.size()), 64'd0);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    @(posedge clk); #1;
    app_rd_data_valid = 1'b1;
    app_rd_data       = d;
  endtask

  task automatic beat_idle();
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
  endtask

  // Client model: each channel presents the head of its queue until granted.
  always @(negedge clk) rdy_snap <= ch_req_ready;
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (rdy_snap[i] === 1'b1 && req_q[i].size() > 0) void'(req_q[i].pop_front());
    #2;
    for (int i = 0; i < NCH; i++) begin
      if (req_q[i].size() > 0) begin
        ch_req_valid[i]            = 1'b1;
        ch_req_we[i]               = req_q[i][0].we;
        ch_req_addr[i*AW +: AW]    = req_q[i][0].addr;
        ch_req_wdata[i*DW +: DW]   = req_q[i][0].wdata;
        ch_req_wmask[i*MW +: MW]   = req_q[i][0].wmask;
      end else begin
        ch_req_valid[i] = 1'b0;
      end
    end
  end

  // Scoreboard monitor on the app side and the read-return side.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (app_en && app_rdy) begin
        if (cmd_q.size() == 0) chk("cmd_extra", 64'(cmd_q.size()), 64'd1);
        else begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("app_cmd", 64'(app_cmd), 64'(e.cmd));
          chk("app_addr", 64'(app_addr), 64'(e.addr));
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (wdf_q.size() == 0) chk("wdf_extra", 64'(wdf_q.size()), 64'd1);
        else begin
          wdf_t w;
          w = wdf_q.pop_front();
          chk("wdf_data", app_wdf_data, w.data);
          chk("wdf_mask", 64'(app_wdf_mask), 64'(w.mask));
          chk("wdf_end", 64'(app_wdf_end), 64'd1);
        end
      end
      if (ch_rd_valid != '0) begin
        if (rd_q.size() == 0) chk("rd_extra", 64'(ch_rd_valid), 64'd0);
        else begin
          rd_t x;
          x = rd_q.pop_front();
          chk("rd_onehot", 64'(ch_rd_valid), 64'(x.oh));
          chk("rd_data", ch_rd_data, x.data);
        end
      end
    end
  end

  initial begin
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;

    // Reset with calibration low, every channel requesting writes.
    for (int i = 0; i < NCH; i++) begin
      req_q[i].push_back(mk(i, 1'b1, 0));
      exp_cmd(mk(i, 1'b1, 0));
    end
    req_q[0].push_back(mk(0, 1'b1, 1));
    exp_cmd(mk(0, 1'b1, 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ch_req_ready), 64'd0);
    chk("rst_app_en", 64'(app_en), 64'd0);
    chk("rst_wren", 64'(app_wdf_wren), 64'd0);
    chk("rst_rd_valid", 64'(ch_rd_valid), 64'd0);
    chk("rst_err", 64'(err_orphan_rd), 64'd0);
    chk("rst_addr", 64'(app_addr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("calib_ready", 64'(ch_req_ready), 64'd0);
    chk("calib_app_en", 64'(app_en), 64'd0);
    @(posedge clk); #1 init_calib_complete = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", 64'(ch_req_ready), 64'b0001);
    @(negedge clk);
    chk("grant_to_en", 64'(app_en), 64'd1);
    chk("grant_to_addr", 64'(app_addr), 64'(mk(0, 1'b1, 0).addr));
    wait_drain("wr_rr_drain", 60);

    // Write data back-pressured for five cycles after the command is taken.
    @(posedge clk); #1;
    app_wdf_rdy = 1'b0;
    req_q[1].push_back(mk(1, 1'b1, 5)); exp_cmd(mk(1, 1'b1, 5));
    req_q[2].push_back(mk(2, 1'b1, 5)); exp_cmd(mk(2, 1'b1, 5));
    @(negedge clk);
    chk("bp_grant", 64'(ch_req_ready), 64'b0010);
    @(negedge clk);
    chk("bp_en_first", 64'(app_en), 64'd1);
    chk("bp_wren_first", 64'(app_wdf_wren), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        @(posedge clk); #1 app_wdf_rdy = 1'b1;
      end
      @(negedge clk);
      chk("bp_en_drop", 64'(app_en), 64'd0);
      chk("bp_wren_hold", 64'(app_wdf_wren), 64'd1);
      chk("bp_no_grant", 64'(ch_req_ready), 64'd0);
    end
    @(negedge clk);
    chk("bp_next_grant", 64'(ch_req_ready), 64'b0100);
    wait_drain("bp_drain", 40);

    // Channel 2 fills the tag FIFO; channel 1 writes keep flowing.
    @(posedge clk); #1;
    req_q[1].push_back(mk(1, 1'b1, 10));
    req_q[1].push_back(mk(1, 1'b1, 11));
    for (int k = 0; k <= TD; k++) req_q[2].push_back(mk(2, 1'b0, k));
    exp_cmd(mk(1, 1'b1, 10));
    exp_cmd(mk(2, 1'b0, 0));
    exp_cmd(mk(1, 1'b1, 11));
    for (int k = 1; k < TD; k++) exp_cmd(mk(2, 1'b0, k));
    wait_drain("rd_fill_drain", 200);
    repeat (4) @(negedge clk);
    chk("full_block_ready", 64'(ch_req_ready), 64'd0);
    chk("full_block_en", 64'(app_en), 64'd0);
    @(posedge clk); #1;
    req_q[1].push_back(mk(1, 1'b1, 12));
    exp_cmd(mk(1, 1'b1, 12));
    wait_drain("full_write_pass", 40);
    exp_cmd(mk(2, 1'b0, TD));
    for (int k = 0; k < TD; k++) exp_rd(2, 64'hD200_0000 + 64'(k));
    for (int k = 0; k < TD; k++) beat(64'hD200_0000 + 64'(k));
    beat_idle();
    wait_drain("rd17_issue", 40);
    exp_rd(2, 64'hD200_0000 + 64'(TD));
    beat(64'hD200_0000 + 64'(TD));
    beat_idle();
    wait_rd("rd_fill_return", 40);

    // Interleaved reads 0, 3, 1 and their tagged returns.
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (k == 0) ? 0 : (k == 1) ? 3 : 1;
      @(posedge clk); #1;
      req_q[c].push_back(mk(c, 1'b0, 20 + k));
      exp_cmd(mk(c, 1'b0, 20 + k));
      wait_drain("ilv_issue", 40);
    end
    exp_rd(0, 64'hA); exp_rd(3, 64'hB); exp_rd(1, 64'hC);
    beat(64'hA);
    @(negedge clk);
    chk("ilv_lat_early", 64'(ch_rd_valid), 64'd0);
    beat(64'hB);
    @(negedge clk);
    chk("ilv_lat_oh", 64'(ch_rd_valid), 64'b0001);
    chk("ilv_lat_data", ch_rd_data, 64'hA);
    beat(64'hC);
    beat_idle();
    wait_rd("ilv_return", 20);

    // Orphan read data, then reset mid-issue with a tag outstanding.
    beat(64'hDEAD);
    beat_idle();
    @(negedge clk);
    chk("orphan_err", 64'(err_orphan_rd), 64'd1);
    chk("orphan_no_valid", 64'(ch_rd_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("orphan_sticky", 64'(err_orphan_rd), 64'd1);
    @(posedge clk); #1;
    req_q[3].push_back(mk(3, 1'b0, 30));
    exp_cmd(mk(3, 1'b0, 30));
    wait_drain("pend_rd_issue", 40);
    @(posedge clk); #1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    req_q[0].push_back(mk(0, 1'b1, 31));
    for (int c = 0; c < 20 && app_en !== 1'b1; c++) @(negedge clk);
    chk("mid_issue_en", 64'(app_en), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(negedge clk);
    chk("mrst_app_en", 64'(app_en), 64'd0);
    chk("mrst_wren", 64'(app_wdf_wren), 64'd0);
    chk("mrst_err", 64'(err_orphan_rd), 64'd0);
    chk("mrst_rd_valid", 64'(ch_rd_valid), 64'd0);
    chk("mrst_addr", 64'(app_addr), 64'd0);
    beat(64'hBEEF);
    beat_idle();
    @(negedge clk);
    chk("mrst_fifo_flushed", 64'(err_orphan_rd), 64'd1);
    chk("mrst_no_valid", 64'(ch_rd_valid), 64'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_app_mport_arb.md
# ddr_app_mport_arb

Multi-channel front-end for the DDR4 controller user (app) interface. Arbitrates `NUM_CH` independent read/write request channels round-robin onto the single app command and write-data path. Routes returned read data back to the issuing channel through an in-order tag FIFO. Sits between client masters and the DDR wrapper top, in the controller's `clk` domain.

## Interface

- `NUM_CH`, 4: number of client channels, 2..8
- `APP_ADDR_WIDTH`, 32: app address width
- `APP_DATA_WIDTH`, 64: app data width
- `APP_MASK_WIDTH`, `APP_DATA_WIDTH/8`: byte-mask width
- `RD_TAG_DEPTH`, 16: outstanding reads tracked, power of two

Ports:

- `clk` in 1: controller UI clock; the only clock
- `rst_n` in 1: synchronous, active-low reset
- `init_calib_complete` in 1: controller calibration done
- `ch_req_valid` in NUM_CH: per-channel request valid
- `ch_req_ready` out NUM_CH: per-channel accept; one-hot or zero
- `ch_req_we` in NUM_CH: 1 = write, 0 = read
- `ch_req_addr` in NUM_CH*APP_ADDR_WIDTH: flattened addresses; channel i at slice i
- `ch_req_wdata` in NUM_CH*APP_DATA_WIDTH: flattened write data
- `ch_req_wmask` in NUM_CH*APP_MASK_WIDTH: flattened masks; 1 = byte masked
- `ch_rd_valid` out NUM_CH: one-hot read-return strobe
- `ch_rd_data` out APP_DATA_WIDTH: shared read-return data
- `app_addr` out APP_ADDR_WIDTH: controller address
- `app_cmd` out 3: 3'b000 write, 3'b001 read
- `app_en` out 1: command valid
- `app_rdy` in 1: command accepted when high with `app_en`
- `app_wdf_data` out APP_DATA_WIDTH: write data
- `app_wdf_mask` out APP_MASK_WIDTH: write mask
- `app_wdf_wren` out 1: write data valid
- `app_wdf_end` out 1: equal to `app_wdf_wren` (single-beat)
- `app_wdf_rdy` in 1: write data accepted when high with `app_wdf_wren`
- `app_rd_data` in APP_DATA_WIDTH: read data
- `app_rd_data_valid` in 1: read data valid
- `err_orphan_rd` out 1: sticky; read data arrived with tag FIFO empty

## Operation

FSM states:

- `CALIB`: wait for `init_calib_complete`, then go to `IDLE`.
- `IDLE`:
  - If `init_calib_complete` is low, return to `CALIB`.
  - Otherwise grant the first eligible channel at or after `rr_ptr`, wrapping.
  - Eligible means `ch_req_valid` is high, and for reads the tag FIFO is not full.
  - On grant: pulse `ch_req_ready[g]`, latch we/addr/wdata/wmask into the holding register, set `rr_ptr = g+1` mod NUM_CH, go to `ISSUE`.
- `ISSUE`:
  - Drive `app_en` with the latched address and command.
  - For writes, also drive `app_wdf_wren`.
  - `cmd_done` sets on `app_en & app_rdy`; `app_en` drops the cycle after.
  - `wdf_done` sets on `app_wdf_wren & app_wdf_rdy`; `app_wdf_wren` drops the cycle after.
  - Command and data are accepted independently, in either order or the same cycle.
  - Reads push the granted channel index into the tag FIFO on command acceptance.
  - When `cmd_done` (and `wdf_done` for writes) is set, go to `IDLE`.
- A calibration drop during `ISSUE` completes the current command, then the FSM goes to `CALIB`.

Read return:

- On `app_rd_data_valid`, pop the tag FIFO.
- Next cycle: `ch_rd_valid[tag]=1`, `ch_rd_data=app_rd_data` (both registered).
- If the FIFO is empty: set `err_orphan_rd`, pop nothing, assert no `ch_rd_valid`.
- A push and a pop in the same cycle are both legal, including when the FIFO is full.

Reset: all outputs 0, FSM in `CALIB`, `rr_ptr=0`, tag FIFO flushed, `err_orphan_rd` cleared.

## Timing

- Grant in cycle T; `app_en` first high at T+1.
- Minimum issue-to-issue spacing is 2 cycles.
- Read return latency: `app_rd_data_valid` at T gives `ch_rd_valid` at T+1.
- `ch_req_ready` is only asserted in `IDLE`, combinationally from `ch_req_valid` and FIFO status.
- `app_*` outputs come from registers only.
- At most one grant per cycle.

## Configuration

`DDR_MPORT_PERF_CNT_EN`:

- Defined:
  - Adds output `perf_rd_cnt` and output `perf_wr_cnt`, each NUM_CH*32 bits, flattened.
  - Read counters increment on each `ch_rd_valid[i]`.
  - Write counters increment on each write's completion.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

## Structure

- Package `ddr_mport_pkg`:
  - `APP_CMD_WR`/`APP_CMD_RD` constants
  - FSM state enum (`CALIB`, `IDLE`, `ISSUE`)
  - `ch_idx_t` width `$clog2(NUM_CH)` helper function
- Sub-module `ddr_mport_tag_fifo`:
  - Synchronous FIFO of channel indices, depth `RD_TAG_DEPTH`
  - full/empty flags
  - same-cycle push+pop
- Arbiter and FSM stay in the top.

## Test plan

- Reset held, `init_calib_complete=0`, all channels valid → no `ch_req_ready`, `app_en=0`; raise calib → ch0 granted first.
- All 4 channels issue continuous writes, `app_rdy=app_wdf_rdy=1` → grant order 0,1,2,3,0; `app_cmd=000`; data/mask match each channel.
- Write with `app_wdf_rdy` low for 5 cycles after command acceptance → `app_en` drops after 1 cycle, `app_wdf_wren` holds 5 extra cycles, next grant only after data accepted.
- Ch2 issues 16 reads with no return → 17th read blocked while ch1 writes still granted; then 16 `app_rd_data_valid` beats → 16 `ch_rd_valid[2]` pulses in order.
- Interleaved reads ch0, ch3, ch1 with data 0xA, 0xB, 0xC → `ch_rd_valid` one-hot 0001/1000/0010 with matching data, each one cycle after the valid beat.
- `app_rd_data_valid` with FIFO empty → `err_orphan_rd=1` sticky, no `ch_rd_valid`; `rst_n` low for 1 cycle mid-`ISSUE` → all outputs 0, FIFO empty, error cleared.
